// File: rtl/mdu_pkg.sv
// Shared op codes, FSM state encoding and op-class helpers for the iterative MDU.
package mdu_pkg;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFLO  = 4'd5;
  localparam logic [3:0] OP_MFHI  = 4'd6;
  localparam logic [3:0] OP_MTLO  = 4'd7;
  localparam logic [3:0] OP_MTHI  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_t;

  function automatic logic is_long_op(input logic [3:0] op);
    return (op == OP_MULT)  || (op == OP_MULTU) || (op == OP_DIV)  || (op == OP_DIVU) ||
           (op == OP_MADD)  || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Ops whose operands are two's complement and need magnitude/sign handling.
  function automatic logic is_signed_op(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

endpackage

// File: rtl/mdu_seq_core.sv
// Radix-2 shift datapath: one multiply (shift-add) or restoring-divide bit per cycle.
module mdu_seq_core
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               start_div,
  input  logic               run,
  input  logic [WIDTH-1:0]   mag_a,
  input  logic [WIDTH-1:0]   mag_b,
  output logic [2*WIDTH-1:0] acc_o,
  output logic               last_o
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic [CW-1:0]      cnt;
  logic               is_div;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_next;

  // acc holds {partial product, remaining multiplier} or {remainder, dividend/quotient};
  // a negative trial difference (borrow in the top bit) means the divisor did not fit.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, opnd};
    div_ge    = ~div_diff[WIDTH];
    div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_next  = {div_rem, acc[WIDTH-2:0], div_ge};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      opnd   <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
    end else if (start) begin
      acc    <= {{WIDTH{1'b0}}, mag_a};
      opnd   <= mag_b;
      cnt    <= '0;
      is_div <= start_div;
    end else if (run) begin
      acc    <= is_div ? div_next : mul_next;
      cnt    <= cnt + CW'(1);
    end
  end

  assign acc_o  = acc;
  assign last_o = run && (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with HI/LO: op decode, accept/flush/busy, sign fix-up
// and special-case results around the mdu_seq_core datapath.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic [WIDTH-1:0] out_o
);

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             state;
  logic [WIDTH-1:0]   hi, lo;
  logic [3:0]         op_q;
  logic               sign_a, sign_b;
  logic               div_zero, div_ovf;
  logic [WIDTH-1:0]   a_raw;

  logic               in_signed;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               core_start, core_run, core_last;
  logic [2*WIDTH-1:0] core_acc;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo_s, rem_s;
  logic [2*WIDTH-1:0] result;

  assign in_signed  = is_signed_op(op_i);
  assign mag_a      = (in_signed && a_i[WIDTH-1]) ? -a_i : a_i;
  assign mag_b      = (in_signed && b_i[WIDTH-1]) ? -b_i : b_i;
  assign core_start = (state == ST_IDLE) && valid_i && !flush_i && is_long_op(op_i);
  assign core_run   = (state == ST_MUL) || (state == ST_DIV);

  mdu_seq_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .reset     (reset),
    .start     (core_start),
    .start_div (is_div_op(op_i)),
    .run       (core_run),
    .mag_a     (mag_a),
    .mag_b     (mag_b),
    .acc_o     (core_acc),
    .last_o    (core_last)
  );

  // HI/LO cannot change while busy, so the live registers equal the values at accept.
  always_comb begin
    prod  = (sign_a ^ sign_b) ? -core_acc : core_acc;
    quo_s = (sign_a ^ sign_b) ? -core_acc[WIDTH-1:0] : core_acc[WIDTH-1:0];
    rem_s = sign_a ? -core_acc[2*WIDTH-1:WIDTH] : core_acc[2*WIDTH-1:WIDTH];
    result = {hi, lo};
    case (op_q)
      OP_MULT, OP_MULTU: result = prod;
      OP_MADD, OP_MADDU: result = {hi, lo} + prod;
      OP_MSUB, OP_MSUBU: result = {hi, lo} - prod;
      OP_DIV, OP_DIVU: begin
        if (div_zero)     result = {a_raw, {WIDTH{1'b1}}};
        else if (div_ovf) result = {{WIDTH{1'b0}}, MIN_VAL};
        else              result = {rem_s, quo_s};
      end
      default: result = {hi, lo};
    endcase
  end

  // Flush wins over everything but reset and drops any op presented alongside it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      hi       <= '0;
      lo       <= '0;
      op_q     <= OP_NONE;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      div_zero <= 1'b0;
      div_ovf  <= 1'b0;
      a_raw    <= '0;
    end else if (flush_i) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (valid_i) begin
            if (op_i == OP_MTHI) begin
              hi <= a_i;
            end else if (op_i == OP_MTLO) begin
              lo <= a_i;
            end else if (is_long_op(op_i)) begin
              op_q     <= op_i;
              sign_a   <= in_signed && a_i[WIDTH-1];
              sign_b   <= in_signed && b_i[WIDTH-1];
              div_zero <= (b_i == '0);
              div_ovf  <= in_signed && (a_i == MIN_VAL) && (b_i == {WIDTH{1'b1}});
              a_raw    <= a_i;
              state    <= is_div_op(op_i) ? ST_DIV : ST_MUL;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (core_last) state <= ST_FIX;
        end
        ST_FIX: begin
          hi    <= result[2*WIDTH-1:WIDTH];
          lo    <= result[WIDTH-1:0];
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy_o = (state != ST_IDLE) || (valid_i && is_long_op(op_i));
  assign out_o  = (op_i == OP_MFHI) ? hi : lo;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed and randomized bench for mdu_iter against a cycle-level arithmetic reference model.
module tb_mdu_iter;
  import mdu_pkg::*;

  localparam int W = 32;

  logic        clk = 1'b0;
  logic        reset, valid_i, flush_i;
  logic [3:0]  op_i;
  logic [31:0] a_i, b_i;
  logic        busy_o;
  logic [31:0] out_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_hi, m_lo;
  logic [63:0] m_pend;
  int          m_left = 0;
  logic        m_ok = 1'b0;

  always #5 clk = ~clk;

  mdu_iter #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .valid_i (valid_i),
    .op_i    (op_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .flush_i (flush_i),
    .busy_o  (busy_o),
    .out_o   (out_o)
  );

  function automatic logic tbLong(input logic [3:0] op);
    return op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd9, 4'd10, 4'd11, 4'd12};
  endfunction

  // Expected {HI,LO} after a long op, from plain 64-bit and 32-bit arithmetic.
  function automatic logic [63:0] refResult(input logic [3:0] op, input logic [31:0] a, b, hi, lo);
    longint      sa, sb;
    logic [63:0] ps, pu, acc;
    int          qa, qb;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ps  = sa * sb;
    pu  = {32'b0, a} * {32'b0, b};
    acc = {hi, lo};
    case (op)
      OP_MULT:  return ps;
      OP_MULTU: return pu;
      OP_MADD:  return acc + ps;
      OP_MADDU: return acc + pu;
      OP_MSUB:  return acc - ps;
      OP_MSUBU: return acc - pu;
      OP_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        qa = $signed(a);
        qb = $signed(b);
        return {qa % qb, qa / qb};
      end
      OP_DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
      default: return acc;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic rs, input logic v, input logic [3:0] op,
                               input logic [31:0] a, input logic [31:0] b, input logic fl);
    @(negedge clk);
    reset = rs; valid_i = v; op_i = op; a_i = a; b_i = b; flush_i = fl;
    #1;
  endtask

  task automatic waitIdle(input string name, inout int n);
    for (int i = 0; i < 200; i++) begin
      applyStimulus(1'b0, 1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
      if (!busy_o) break;
      n++;
    end
    if (busy_o) checkOutput({name, "_timeout"}, {31'b0, busy_o}, 32'd0);
  endtask

  task automatic runLong(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int n);
    applyStimulus(1'b0, 1'b1, op, a, b, 1'b0);
    n = busy_o ? 1 : 0;
    waitIdle(name, n);
  endtask

  task automatic readHiLo(input string name, input logic [31:0] eh, input logic [31:0] el);
    applyStimulus(1'b0, 1'b1, OP_MFHI, 32'd0, 32'd0, 1'b0);
    checkOutput({name, "_hi"}, out_o, eh);
    applyStimulus(1'b0, 1'b1, OP_MFLO, 32'd0, 32'd0, 1'b0);
    checkOutput({name, "_lo"}, out_o, el);
  endtask

  function automatic logic [31:0] randOperand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'($urandom_range(0, 20));
      4:       return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Model advances on the same edge as the DUT; m_left counts edges until HI/LO are written.
  always @(posedge clk) begin
    if (reset) begin
      m_hi = 32'd0; m_lo = 32'd0; m_left = 0; m_ok = 1'b1;
    end else if (flush_i) begin
      m_left = 0;
    end else if (m_left != 0) begin
      m_left--;
      if (m_left == 0) {m_hi, m_lo} = m_pend;
    end else if (valid_i) begin
      if (op_i == OP_MTHI) m_hi = a_i;
      else if (op_i == OP_MTLO) m_lo = a_i;
      else if (tbLong(op_i)) begin
        m_pend = refResult(op_i, a_i, b_i, m_hi, m_lo);
        m_left = W + 1;
      end
    end
  end

  always @(negedge clk) begin
    logic exp_busy;
    #2;
    if (m_ok) begin
      exp_busy = (m_left != 0) || (valid_i && tbLong(op_i));
      checkOutput("model_busy", {31'b0, busy_o}, {31'b0, exp_busy});
      checkOutput("model_out", out_o, (op_i == OP_MFHI) ? m_hi : m_lo);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          n;
    logic [63:0] r64;
    reset = 1'b1; valid_i = 1'b0; flush_i = 1'b0; op_i = OP_NONE; a_i = '0; b_i = '0;

    r64 = refResult(OP_MULT, 32'hFFFFFFFE, 32'd3, 32'd0, 32'd0);
    checkOutput("ref_mult_hi", r64[63:32], 32'hFFFFFFFF);
    checkOutput("ref_mult_lo", r64[31:0], 32'hFFFFFFFA);
    r64 = refResult(OP_DIV, 32'hFFFFFFF9, 32'd2, 32'd0, 32'd0);
    checkOutput("ref_div_lo", r64[31:0], 32'hFFFFFFFD);

    applyStimulus(1'b1, 1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
    checkOutput("reset_busy", {31'b0, busy_o}, 32'd0);
    checkOutput("reset_out", out_o, 32'd0);

    runLong("mult", OP_MULT, 32'hFFFFFFFE, 32'd3, n);
    checkOutput("mult_busy_cycles", n, 34);
    readHiLo("mult", 32'hFFFFFFFF, 32'hFFFFFFFA);
    runLong("multu", OP_MULTU, 32'hFFFFFFFE, 32'd3, n);
    readHiLo("multu", 32'h00000002, 32'hFFFFFFFA);
    runLong("div", OP_DIV, -32'd7, 32'd2, n);
    checkOutput("div_busy_cycles", n, 34);
    readHiLo("div", 32'hFFFFFFFF, 32'hFFFFFFFD);
    runLong("divu0", OP_DIVU, 32'd7, 32'd0, n);
    readHiLo("divu0", 32'd7, 32'hFFFFFFFF);
    runLong("divovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, n);
    readHiLo("divovf", 32'd0, 32'h80000000);

    applyStimulus(1'b0, 1'b1, OP_MTHI, 32'd0, 32'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, OP_MTLO, 32'hFFFFFFFF, 32'd0, 1'b0);
    runLong("madd", OP_MADD, 32'd1, 32'd1, n);
    readHiLo("madd", 32'd1, 32'd0);
    runLong("msub", OP_MSUB, 32'd1, 32'd2, n);
    readHiLo("msub", 32'd0, 32'hFFFFFFFE);

    applyStimulus(1'b0, 1'b1, OP_DIVU, 32'd100, 32'd7, 1'b0);
    repeat (9) applyStimulus(1'b0, 1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, OP_NONE, 32'd0, 32'd0, 1'b1);
    checkOutput("flush_busy_during", {31'b0, busy_o}, 32'd1);
    applyStimulus(1'b0, 1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
    checkOutput("flush_busy_after", {31'b0, busy_o}, 32'd0);
    readHiLo("flush", 32'd0, 32'hFFFFFFFE);
    runLong("after_flush", OP_MULTU, 32'd6, 32'd7, n);
    readHiLo("after_flush", 32'd0, 32'd42);

    applyStimulus(1'b0, 1'b1, OP_MULT, 32'd5, 32'd5, 1'b0);
    repeat (5) applyStimulus(1'b0, 1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
    checkOutput("midreset_busy", {31'b0, busy_o}, 32'd0);
    readHiLo("midreset", 32'd0, 32'd0);

    applyStimulus(1'b0, 1'b1, OP_MULTU, 32'd6, 32'd7, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, OP_MTLO, 32'h5555, 32'd0, 1'b0);
    n = 0;
    waitIdle("mtlo_busy", n);
    readHiLo("mtlo_ignored", 32'd0, 32'd42);

    applyStimulus(1'b0, 1'b1, OP_MTLO, 32'h1234, 32'd0, 1'b0);
    checkOutput("mtlo_busy", {31'b0, busy_o}, 32'd0);
    applyStimulus(1'b0, 1'b1, OP_MFLO, 32'd0, 32'd0, 1'b0);
    checkOutput("mflo_after_mtlo", out_o, 32'h1234);
    checkOutput("mflo_busy", {31'b0, busy_o}, 32'd0);

    for (int c = 0; c < 4000; c++) begin
      int r;
      r = $urandom_range(0, 255);
      applyStimulus(r == 0, $urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                    randOperand(), randOperand(), r == 1);
    end
    repeat (40) applyStimulus(1'b0, 1'b0, OP_MFHI, 32'd0, 32'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Parametrised iterative multiply/divide unit with HI/LO registers. It is the next-generation MDU for the pipeline's EX stage. It computes results with a radix-2 shift datapath, one bit per cycle, instead of a combinational result plus a delay counter. It adds multiply-accumulate ops, pipeline flush, and fully defined divide-by-zero and overflow results.

## Interface
- WIDTH, 32: operand, HI and LO width; must be even and ≥ 4.
- clk  in  1  clock.
- reset  in  1  reset; synchronous, active-high.
- valid_i  in  1  op_i/a_i/b_i are meaningful this cycle.
- op_i  in  4  operation code (mdu_pkg).
- a_i  in  WIDTH  rs operand.
- b_i  in  WIDTH  rt operand.
- flush_i  in  1  abort any in-flight op (exception/eret).
- busy_o  out  1  unit occupied, or a long op is being issued this cycle.
- out_o  out  WIDTH  HI when op_i = MFHI, otherwise LO.

## Operation
- Op codes: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFLO=5, MFHI=6, MTLO=7, MTHI=8, MADD=9, MADDU=10, MSUB=11, MSUBU=12. Codes 13–15 behave as NONE.
- Long ops are MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB and MSUBU.
- busy_o = (state != IDLE) | (valid_i & op_i is a long op). This is combinational, so a following instruction stalls in the same cycle.
- Accept: an op takes effect only when valid_i = 1, state = IDLE and flush_i = 0. Any op presented while state != IDLE is ignored; the pipeline must not present one.
- MTHI/MTLO: HI or LO ← a_i at the accepting edge, with no busy. The other register is unchanged.
- MFHI/MFLO: purely combinational read of the current registers. The read is valid whenever issued; the pipeline stalls reads while busy.
- States:
  - IDLE → MUL or DIV on accepting a long op. Operand magnitudes are latched and the result sign is recorded.
  - MUL/DIV hold for WIDTH cycles, one iteration each:
    - MUL: shift-add over a 2·WIDTH-bit product.
    - DIV: restoring shift-subtract giving quotient and remainder.
  - FIX takes one cycle. It applies the sign correction, the accumulate/subtract against {HI,LO} latched at accept, and writes HI/LO. Next state is IDLE.
- Signed divide: quotient takes sign(a) XOR sign(b); remainder takes sign(a).
- Divide by zero (b_i = 0), signed or unsigned: LO = all ones, HI = a_i.
- Signed overflow (a = MIN, b = −1): LO = MIN, HI = 0.
- MADD/MSUB: {HI,LO} ← {HI,LO} ± signed 2·WIDTH product, modulo 2^(2·WIDTH).
- MADDU/MSUBU: same, using the unsigned product.
- flush_i = 1 in any state: next state is IDLE, HI/LO are unchanged, and an op presented in the same cycle is discarded.
- Reset (any state): state = IDLE, HI = LO = 0.
- Reset values: busy_o = 0 when valid_i = 0; out_o = 0.

## Timing
- Long op accepted at edge E0. Iterations complete at E1..E_WIDTH, and HI/LO are written at E_(WIDTH+1).
- busy_o is high from the issue cycle through the cycle ending at E_(WIDTH+1). It is low after that edge, and a read then returns the new HI/LO.
- Total occupancy is WIDTH+2 cycles: 34 for WIDTH=32. Latency is identical for all long ops, with no early termination.
- Back-to-back: a new long op can be accepted in the first cycle busy_o is low.
- MTHI/MTLO take effect at their accepting edge; an MFHI/MFLO in the next cycle sees the new value.

## Structure
- Package mdu_pkg holds the op code localparams and the state encoding (IDLE, MUL, DIV, FIX).
- Sub-module mdu_seq_core contains the radix-2 datapath: the shifting accumulator/remainder, the iteration counter and iteration-done detection.
- The top level owns op decode, the accept/flush/busy logic, sign handling, special cases and the HI/LO registers.

## Test plan
Values assume WIDTH = 32.
- MULT a=0xFFFFFFFE, b=3 → busy for 34 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- DIV a=−7, b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=7, b=0 → LO=0xFFFFFFFF, HI=7. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- MTHI 0, MTLO 0xFFFFFFFF, MADD 1×1 → HI=1, LO=0. Then MSUB 1×2 → HI=0, LO=0xFFFFFFFE.
- Start DIVU 100/7, assert flush_i in iteration 10 → busy_o low next cycle, HI/LO unchanged. A following MULTU 6×7 → LO=42.
- Assert reset in mid-MULT → HI=LO=0, busy_o=0. An MTLO issued while busy is ignored, and LO keeps the pending result.
- MTLO 0x1234 followed immediately by MFLO → out_o=0x1234 with busy_o=0.
